// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, fixed-latency memory between an instruction-fetch
// port (I) and a load/store data port (D). Requests are serialised by a registered FSM
// (IDLE -> ISSUE -> [WAIT] -> ACK). D has priority; after STARVE_MAX consecutive D grants
// while i_req is pending, fetch is forced. All outputs are registered.
//
// Optional feature: define MEM_ARB_PERF_EN to build the 32-bit grant counters on
// perf_i_cnt / perf_d_cnt; otherwise both ports are tied to 0.
//
// Ports:
//   clk, reset                     clock (rising edge), async active-high reset
//   i_req/i_addr/i_rdata/i_ack     fetch read port
//   d_req/d_we/d_addr/d_wdata/d_be data port, d_rdata/d_ack results
//   m_en/m_we/m_addr/m_wdata/m_be  memory command (one-cycle m_en strobe)
//   m_rdata                        memory read data, valid MEM_LAT cycles after m_en
//   busy                           FSM not idle
//   perf_i_cnt/perf_d_cnt          grant counters (optional)
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_be,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [1:0]        m_be,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic [31:0]       perf_i_cnt,
    output logic [31:0]       perf_d_cnt
);

    localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

    state_e              state_q, state_d;
    logic                owner_i_q, owner_i_d;   // 1 = fetch owns the access
    logic [StW-1:0]      starve_q, starve_d;
    logic [LatW-1:0]     lat_q, lat_d;
    logic                m_en_q, m_en_d;
    logic                m_we_q, m_we_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [1:0]          m_be_q, m_be_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                busy_q, busy_d;
    logic                grant_v, grant_i;

    always_comb begin
        state_d   = state_q;
        owner_i_d = owner_i_q;
        starve_d  = starve_q;
        lat_d     = lat_q;
        m_en_d    = 1'b0;
        m_we_d    = 1'b0;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_be_d    = m_be_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        grant_v   = 1'b0;
        grant_i   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    grant_v   = 1'b1;
                    grant_i   = i_req && (!d_req || (starve_q == StW'(STARVE_MAX)));
                    owner_i_d = grant_i;
                    m_en_d    = 1'b1;
                    m_we_d    = !grant_i && d_we;
                    m_addr_d  = grant_i ? i_addr : d_addr;
                    m_wdata_d = grant_i ? '0 : d_wdata;
                    m_be_d    = grant_i ? 2'b00 : d_be;
                    state_d   = StIssue;
                    // Count D grants that bypassed a waiting fetch; anything else resets it.
                    if (!grant_i && i_req) begin
                        if (starve_q != StW'(STARVE_MAX)) begin
                            starve_d = starve_q + StW'(1);
                        end
                    end else begin
                        starve_d = '0;
                    end
                end
            end
            StIssue: begin
                // m_we_q is only high during ISSUE, so it identifies a write here.
                if (m_we_q) begin
                    i_ack_d = owner_i_q;
                    d_ack_d = !owner_i_q;
                    state_d = StAck;
                end else begin
                    lat_d   = LatW'(MEM_LAT - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (lat_q == '0) begin
                    if (owner_i_q) begin
                        i_rdata_d = m_rdata;
                    end else begin
                        d_rdata_d = m_rdata;
                    end
                    i_ack_d = owner_i_q;
                    d_ack_d = !owner_i_q;
                    state_d = StAck;
                end else begin
                    lat_d = lat_q - LatW'(1);
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            owner_i_q <= 1'b0;
            starve_q  <= '0;
            lat_q     <= '0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_be_q    <= 2'b00;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_i_q <= owner_i_d;
            starve_q  <= starve_d;
            lat_q     <= lat_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            busy_q    <= busy_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_q, perf_d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_i_q <= '0;
            perf_d_q <= '0;
        end else if (grant_v) begin
            if (grant_i) begin
                perf_i_q <= perf_i_q + 32'd1;
            end else begin
                perf_d_q <= perf_d_q + 32'd1;
            end
        end
    end

    assign perf_i_cnt = perf_i_q;
    assign perf_d_cnt = perf_d_q;
`else
    assign perf_i_cnt = '0;
    assign perf_d_cnt = '0;
`endif

    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_be    = m_be_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (MEM_LAT=2, STARVE_MAX=2). Stimulus pushes expected
// memory commands and acks (with absolute cycle numbers) into queues; a monitor pops and
// compares whenever m_en or an ack is seen.
module tb_mem_arbiter;
    localparam int unsigned MemLat = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [1:0]  d_be = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_be;
    logic [31:0] m_rdata = '0;
    logic        busy;
    logic [31:0] perf_i_cnt;
    logic [31:0] perf_d_cnt;

    mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_LAT   (MemLat),
        .STARVE_MAX(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .m_en      (m_en),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_be      (m_be),
        .m_rdata   (m_rdata),
        .busy      (busy),
        .perf_i_cnt(perf_i_cnt),
        .perf_d_cnt(perf_d_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [1:0]  be;
    } mcmd_t;

    typedef struct {
        int          cyc;
        logic [1:0]  port;   // {i_ack, d_ack}
        logic [31:0] irdata;
        logic [31:0] drdata;
    } ack_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rd_t;

    mcmd_t mq[$];
    ack_t  aq[$];
    rd_t   rq[$];

    int checks = 0;
    int errors = 0;
    logic prev_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hDEADBEEF;
            32'h20:  return 32'hCAFEF00D;
            32'h30:  return 32'h30303030;
            32'h200: return 32'h12345678;
            32'h404: return 32'h44440404;
            default: return 32'h0BAD0BAD;
        endcase
    endfunction

    // Memory model: read data appears only in the cycle MEM_LAT after m_en.
    always @(negedge clk) begin
        if (!reset && m_en && !m_we) rq.push_back('{cyc + MemLat, mem_rd(m_addr)});
    end

    always @(posedge clk) begin
        #1;
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            m_rdata = rq[0].data;
            void'(rq.pop_front());
        end else begin
            m_rdata = 32'hF0F0F0F0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!reset) begin
            chk("m_we_without_m_en", {63'd0, m_we & ~m_en}, 64'd0);
            if (m_en) begin
                chk("m_en_back_to_back", {63'd0, prev_en}, 64'd0);
                if (mq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_m_en: m_addr %0h at cycle %0d, none expected",
                             m_addr, cyc);
                end else begin
                    mcmd_t e;
                    e = mq.pop_front();
                    chk("m_en_cycle", 64'(cyc), 64'(e.cyc));
                    chk("m_addr", {32'd0, m_addr}, {32'd0, e.addr});
                    chk("m_we", {63'd0, m_we}, {63'd0, e.we});
                    chk("m_wdata", {32'd0, m_wdata}, {32'd0, e.wdata});
                    chk("m_be", {62'd0, m_be}, {62'd0, e.be});
                end
            end
            if (i_ack || d_ack) begin
                if (aq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: i_ack %0b d_ack %0b at cycle %0d, none expected",
                             i_ack, d_ack, cyc);
                end else begin
                    ack_t a;
                    a = aq.pop_front();
                    chk("ack_port", {62'd0, i_ack, d_ack}, {62'd0, a.port});
                    chk("ack_cycle", 64'(cyc), 64'(a.cyc));
                    chk("i_rdata", {32'd0, i_rdata}, {32'd0, a.irdata});
                    chk("d_rdata", {32'd0, d_rdata}, {32'd0, a.drdata});
                end
            end
        end
        prev_en <= m_en;
    end

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_cmd"}, {m_en, m_we, m_be, m_addr, 28'd0}, 64'd0);
        chk({tag, "_m_wdata"}, {32'd0, m_wdata}, 64'd0);
        chk({tag, "_acks_busy"}, {61'd0, i_ack, d_ack, busy}, 64'd0);
        chk({tag, "_rdata"}, {i_rdata, d_rdata}, 64'd0);
    endtask

    initial begin
        // Reset held, then released with no requests
        at_cycle(1);
        chk_all_zero("reset");
        at_cycle(2);
        reset = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            at_cycle(c);
            chk("idle_no_m_en", {62'd0, m_en, busy}, 64'd0);
        end

        // Single fetch
        at_cycle(10);
        i_req = 1'b1; i_addr = 32'h10;
        mq.push_back('{11, 32'h10, 1'b0, 32'h0, 2'b00});
        aq.push_back('{14, 2'b10, 32'hDEADBEEF, 32'h0});
        at_cycle(15);
        i_req = 1'b0; i_addr = '0;

        // Store
        at_cycle(20);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h55; d_be = 2'b10;
        mq.push_back('{21, 32'h100, 1'b1, 32'h55, 2'b10});
        aq.push_back('{22, 2'b01, 32'hDEADBEEF, 32'h0});
        at_cycle(23);
        d_req = 1'b0; d_we = 1'b0;

        // Contention: D load wins, fetch follows after one IDLE cycle
        at_cycle(30);
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_addr = 32'h200; d_wdata = 32'h77; d_be = 2'b01;
        mq.push_back('{31, 32'h200, 1'b0, 32'h77, 2'b01});
        aq.push_back('{34, 2'b01, 32'hDEADBEEF, 32'h12345678});
        mq.push_back('{36, 32'h20, 1'b0, 32'h0, 2'b00});
        aq.push_back('{39, 2'b10, 32'hCAFEF00D, 32'h12345678});
        at_cycle(31);
        d_addr = 32'h204;  // already latched, must not reach memory
        at_cycle(35);
        d_req = 1'b0;
        at_cycle(40);
        i_req = 1'b0;

        // Starvation guard: D, D, I, D, D, I with both requests held
        at_cycle(50);
        i_req = 1'b1; i_addr = 32'h30;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hAA; d_be = 2'b10;
        mq.push_back('{51, 32'h300, 1'b1, 32'hAA, 2'b10});
        aq.push_back('{52, 2'b01, 32'hCAFEF00D, 32'h12345678});
        mq.push_back('{54, 32'h300, 1'b1, 32'hAA, 2'b10});
        aq.push_back('{55, 2'b01, 32'hCAFEF00D, 32'h12345678});
        mq.push_back('{57, 32'h30, 1'b0, 32'h0, 2'b00});
        aq.push_back('{60, 2'b10, 32'h30303030, 32'h12345678});
        mq.push_back('{62, 32'h300, 1'b1, 32'hAA, 2'b10});
        aq.push_back('{63, 2'b01, 32'h30303030, 32'h12345678});
        mq.push_back('{65, 32'h300, 1'b1, 32'hAA, 2'b10});
        aq.push_back('{66, 2'b01, 32'h30303030, 32'h12345678});
        mq.push_back('{68, 32'h30, 1'b0, 32'h0, 2'b00});
        aq.push_back('{71, 2'b10, 32'h30303030, 32'h12345678});
        at_cycle(67);
        d_req = 1'b0; d_we = 1'b0;
        at_cycle(72);
        i_req = 1'b0;

        // Reset during the first WAIT cycle abandons the access
        at_cycle(80);
        d_req = 1'b1; d_addr = 32'h400; d_wdata = 32'h0; d_be = 2'b10;
        mq.push_back('{81, 32'h400, 1'b0, 32'h0, 2'b10});
        at_cycle(82);
        chk("wait_busy", {63'd0, busy}, 64'd1);
        #3;
        reset = 1'b1;
        d_req = 1'b0;
        rq.delete();
        #1;
        chk_all_zero("async_reset");
        at_cycle(84);
        reset = 1'b0;
        at_cycle(86);
        d_req = 1'b1; d_addr = 32'h404; d_be = 2'b00;
        mq.push_back('{87, 32'h404, 1'b0, 32'h0, 2'b00});
        aq.push_back('{90, 2'b01, 32'h0, 32'h44440404});
        at_cycle(91);
        d_req = 1'b0;

        at_cycle(100);
        chk("ack_queue_drained", 64'(aq.size()), 64'd0);
        chk("mcmd_queue_drained", 64'(mq.size()), 64'd0);
`ifdef MEM_ARB_PERF_EN
        chk("perf_i_cnt", {32'd0, perf_i_cnt}, 64'd0);
        chk("perf_d_cnt", {32'd0, perf_d_cnt}, 64'd1);
`else
        chk("perf_tied", {perf_i_cnt, perf_d_cnt}, 64'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
